multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle MIPS-style datapath.
//
// Walks IDLE -> FETCH -> DECODE -> EXEC -> MEM -> WB (each instruction uses the
// subset of phases it needs) and stops in HALT once FETCH sees pc == INSTR_COUNT.
//
// Parameters:
//   PC_WIDTH     program-counter width
//   INSTR_COUNT  pc value at which execution halts
// Ports:
//   clock, reset     single clock; synchronous active-high reset
//   start            leave IDLE (ignored elsewhere)
//   step             (SINGLE_STEP_EN only) FETCH waits until step=1
//   opcode           instruction[31:26]; latched in DECODE
//   zero             ALU zero flag, used by beq in EXEC
//   pc               current program counter
//   pc_write .. mem_to_reg, pc_src, alu_op   datapath strobes and selects
//   busy, done       FETCH..WB / HALT status
//   retired          retired-instruction count, wraps at 256
// Optional feature macro: SINGLE_STEP_EN
module multicycle_control #(
    parameter int PC_WIDTH    = 6,
    parameter int INSTR_COUNT = 24
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic [5:0]          opcode,
    input  logic                zero,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_op,
    output logic                busy,
    output logic                done,
    output logic [7:0]          retired
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [2:0] {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_NOP} kind_t;

    state_t state, state_next;
    kind_t  kind_q, kind_dec;
    logic   retire;
    logic   step_ok;
    logic   at_end;

`ifdef SINGLE_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign at_end = (pc == PC_WIDTH'(INSTR_COUNT));

    always_comb begin
        case (opcode)
            6'b000000: kind_dec = K_R;
            6'b001000: kind_dec = K_ADDI;
            6'b100011: kind_dec = K_LW;
            6'b101011: kind_dec = K_SW;
            6'b000100: kind_dec = K_BEQ;
            6'b000010: kind_dec = K_J;
            default:   kind_dec = K_NOP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            kind_q  <= K_NOP;
            retired <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) kind_q <= kind_dec;
            if (retire) retired <= retired + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = FETCH;
            FETCH: begin
                busy = 1'b1;
                if (at_end) begin
                    state_next = HALT;
                end else if (step_ok) begin
                    ir_write   = 1'b1;
                    mem_read   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                busy = 1'b1;
                // Routing uses the live opcode; later phases use the latched copy.
                case (kind_dec)
                    K_NOP: begin
                        state_next = FETCH;
                        retire     = 1'b1;
                    end
                    default: state_next = EXEC;
                endcase
            end
            EXEC: begin
                busy = 1'b1;
                case (kind_q)
                    K_R:         begin alu_op = 2'b10; state_next = WB; end
                    K_ADDI:      state_next = WB;
                    K_LW, K_SW:  state_next = MEM;
                    K_BEQ: begin
                        alu_op     = 2'b01;
                        pc_src     = 2'b01;
                        pc_write   = zero;
                        state_next = FETCH;
                        retire     = 1'b1;
                    end
                    default: begin
                        pc_src     = 2'b10;
                        pc_write   = 1'b1;
                        state_next = FETCH;
                        retire     = 1'b1;
                    end
                endcase
            end
            MEM: begin
                busy = 1'b1;
                if (kind_q == K_LW) begin
                    mem_read   = 1'b1;
                    state_next = WB;
                end else begin
                    mem_write  = 1'b1;
                    state_next = FETCH;
                    retire     = 1'b1;
                end
            end
            WB: begin
                busy       = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = (kind_q == K_R);
                mem_to_reg = (kind_q == K_LW);
                state_next = FETCH;
                retire     = 1'b1;
            end
            HALT: done = 1'b1;
            default: state_next = IDLE;
        endcase
        // Reset cycle issues nothing, even when it lands mid-instruction.
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            pc_src     = 2'b00;
            alu_op     = 2'b00;
            busy       = 1'b0;
            done       = 1'b0;
        end
    end

endmodule
